// File: rtl/phy_tx_ctrl.sv
// PHY transmit controller: link bring-up FSM with a holding FIFO that feeds
// the striping/serializer path, emitting COM filler when no payload is sent.
module phy_tx_ctrl #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          COM_CYCLES = 4,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0]    IDLE_WORD  = DATA_W'(32'hBCBCBCBC)
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        lane_ok,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              fifo_full,
  output logic              overflow,
  output logic              error,
  output logic [2:0]        state
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = AW + 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] ONE_C    = OCC_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COM_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_out_q, valid_out_d;
  logic                active_q, active_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                lane_good;
  logic                pop;
  logic                push;
  logic                drop;

  // FIFO handshake decode from the current state and occupancy.
  always_comb begin
    lane_good = (lane_ok == 2'b11);
    pop       = ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN)) && (occ_q != '0);
    push      = valid && (state_q inside {ST_INIT, ST_IDLE, ST_ACTIVE}) &&
                ((occ_q != DEPTH_C) || pop);
    drop      = valid && !push;
  end

  // Next-state logic and COM qualification counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        if (enable && lane_good) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!enable) begin
          state_d = ST_INIT;
        end else if (lane_good) begin
          if (cnt_q == CNT_LAST) state_d = ST_ACTIVE;
          else                   cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (!lane_good)   state_d = ST_ERROR;
        else if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // occ_q of 1 means the last entry pops on this edge.
        if (!lane_good)         state_d = ST_ERROR;
        else if (occ_q <= ONE_C) state_d = ST_INIT;
      end
      ST_ERROR: begin
        if (!enable) state_d = ST_INIT;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // FIFO pointer/occupancy update and registered output values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    // Entering (or sitting in) ERROR discards everything queued.
    if (state_d == ST_ERROR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
    data_d      = pop ? mem_q[rd_ptr_q] : IDLE_WORD;
    valid_out_d = pop;
    active_d    = (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
    full_d      = (occ_d == DEPTH_C);
    ovf_d       = ovf_q | drop;
    err_d       = (state_d == ST_ERROR);
  end

  // Control and output registers.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      data_q      <= IDLE_WORD;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      data_q      <= data_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage; contents are don't-care while occupancy is zero.
  always_ff @(posedge clk_f) begin
    if (push) mem_q[wr_ptr_q] <= data_input;
  end

  assign data_out  = data_q;
  assign valid_out = valid_out_q;
  assign active    = active_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Self-checking bench for phy_tx_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based behavioural model.
module tb_phy_tx_ctrl;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;
  localparam int COM = 4;
  localparam int FD  = 4;
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_DRAIN = 4, M_ERROR = 5;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  lane_ok;
  logic [31:0] data_input;
  logic        valid;
  logic [31:0] data_out;
  logic        valid_out, active, fifo_full, overflow, error;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int          m_state;
  int          m_run;
  logic [31:0] m_q[$];
  logic [31:0] m_dout;
  logic        m_vout;
  logic        m_ovf;

  phy_tx_ctrl #(
    .DATA_W(32), .COM_CYCLES(COM), .FIFO_DEPTH(FD), .IDLE_WORD(32'hBCBCBCBC)
  ) dut (
    .clk_f(clk_f), .reset(reset), .enable(enable), .lane_ok(lane_ok),
    .data_input(data_input), .valid(valid), .data_out(data_out),
    .valid_out(valid_out), .active(active), .fifo_full(fifo_full),
    .overflow(overflow), .error(error), .state(state)
  );

  always #5 clk_f = ~clk_f;

  task automatic model_reset();
    m_state = M_RESET;
    m_run   = 0;
    m_q.delete();
    m_dout  = IDLE;
    m_vout  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the link rules, evaluated on the inputs in force.
  task automatic model_edge();
    int          ns;
    int          occ_before;
    bit          good, do_pop, do_push;
    logic [31:0] w;
    good       = (lane_ok == 2'b11);
    occ_before = m_q.size();
    do_pop     = (m_state == M_ACTIVE || m_state == M_DRAIN) && occ_before > 0;
    do_push    = valid && (m_state == M_INIT || m_state == M_IDLE || m_state == M_ACTIVE)
                 && (occ_before < FD || do_pop);
    if (valid && !do_push) m_ovf = 1'b1;
    w = IDLE;
    if (do_pop) w = m_q.pop_front();
    ns = m_state;
    case (m_state)
      M_RESET:  ns = M_INIT;
      M_INIT:   if (enable && good) ns = M_IDLE;
      M_IDLE: begin
        if (!enable) begin
          ns = M_INIT; m_run = 0;
        end else if (!good) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == COM) begin ns = M_ACTIVE; m_run = 0; end
        end
      end
      M_ACTIVE: if (!good) ns = M_ERROR; else if (!enable) ns = M_DRAIN;
      M_DRAIN:  if (!good) ns = M_ERROR; else if (occ_before <= 1) ns = M_INIT;
      M_ERROR:  if (!enable) ns = M_INIT;
      default:  ns = M_RESET;
    endcase
    if (do_push) m_q.push_back(data_input);
    if (ns == M_ERROR) m_q.delete();
    m_state = ns;
    m_dout  = w;
    m_vout  = do_pop;
  endtask

  // Drive one cycle of inputs, advance DUT and model, sample 1 ns after the edge.
  task automatic step(input logic en, input logic [1:0] lo, input logic v, input logic [31:0] d);
    enable = en; lane_ok = lo; valid = v; data_input = d;
    @(posedge clk_f);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; lane_ok = 2'b00; valid = 1'b0; data_input = '0;
    model_reset();
    @(posedge clk_f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; lane_ok = 2'b00; valid = 1'b0; data_input = '0;
    model_reset();
    repeat (2) @(posedge clk_f);
    #1;
    checks++; if (state !== 3'd0)   begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (data_out !== IDLE) begin errors++; $display("FAIL reset_data got %h want %h", data_out, IDLE); end
    checks++; if ({valid_out, active, fifo_full, overflow, error} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got %b want 00000", {valid_out, active, fifo_full, overflow, error}); end
  endtask

  task automatic test_bringup();
    reset = 1'b1;
    step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL bringup_init got %0d want 1", state); end
    step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL bringup_idle got %0d want 2", state); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11, 1'b0, '0);
      checks++;
      if (state !== ((i == 3) ? 3'd3 : 3'd2))
        begin errors++; $display("FAIL bringup_count%0d got %0d want %0d", i, state, (i == 3) ? 3 : 2); end
      checks++;
      if (data_out !== IDLE || valid_out !== 1'b0)
        begin errors++; $display("FAIL bringup_filler got %h/%b want %h/0", data_out, valid_out, IDLE); end
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL bringup_active got %b want 1", active); end
  endtask

  task automatic test_preload();
    logic [31:0] w [4];
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    do_reset();
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b1, w[i]);
    checks++; if (fifo_full !== 1'b1 || state !== 3'd3)
      begin errors++; $display("FAIL preload_full got full=%b st=%0d want 1/3", fifo_full, state); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11, 1'b0, '0);
      checks++;
      if (data_out !== w[i] || valid_out !== 1'b1)
        begin errors++; $display("FAIL preload_out%0d got %h/%b want %h/1", i, data_out, valid_out, w[i]); end
    end
    step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (data_out !== IDLE || valid_out !== 1'b0)
      begin errors++; $display("FAIL preload_empty got %h/%b want %h/0", data_out, valid_out, IDLE); end
  endtask

  task automatic test_lane_glitch();
    do_reset();
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, '0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL glitch_idle got %0d want 2", state); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11, (i < 3), 32'hA0 + 32'(i));
      checks++;
      if (state !== ((i == 3) ? 3'd3 : 3'd2))
        begin errors++; $display("FAIL glitch_recount%0d got %0d want %0d", i, state, (i == 3) ? 3 : 2); end
    end
    step(1'b1, 2'b01, 1'b0, '0);
    checks++; if (state !== 3'd5 || error !== 1'b1 || active !== 1'b0 || fifo_full !== 1'b0)
      begin errors++; $display("FAIL glitch_error got st=%0d err=%b act=%b full=%b want 5/1/0/0", state, error, active, fifo_full); end
    step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd5 || valid_out !== 1'b0)
      begin errors++; $display("FAIL glitch_hold got st=%0d vo=%b want 5/0", state, valid_out); end
    step(1'b0, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd1 || error !== 1'b0)
      begin errors++; $display("FAIL glitch_exit got st=%0d err=%b want 1/0", state, error); end
    for (int i = 0; i < 6; i++) step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL glitch_reactive got %0d want 3", state); end
    step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL glitch_flushed got vo=%b want 0", valid_out); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'h0F000000 + 32'(i);
    do_reset();
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b01, 1'b1, w[i]);
      if (i == 3) begin
        checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0)
          begin errors++; $display("FAIL ovf_fill got full=%b ovf=%b want 1/0", fifo_full, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || state !== 3'd2)
      begin errors++; $display("FAIL ovf_drop got ovf=%b st=%0d want 1/2", overflow, state); end
    for (int i = 0; i < 8; i++) step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    // full FIFO in ACTIVE accepts a word on a pop cycle
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b1, w[i]);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd3 || fifo_full !== 1'b1)
      begin errors++; $display("FAIL fullpop_setup got st=%0d full=%b want 3/1", state, fifo_full); end
    step(1'b1, 2'b11, 1'b1, 32'h55555555);
    checks++; if (overflow !== 1'b0 || fifo_full !== 1'b1 || data_out !== w[0])
      begin errors++; $display("FAIL fullpop_accept got ovf=%b full=%b d=%h want 0/1/%h", overflow, fifo_full, data_out, w[0]); end
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 2'b11, 1'b0, '0);
      checks++;
      if (data_out !== ((i == 4) ? 32'h55555555 : w[i]) || valid_out !== 1'b1)
        begin errors++; $display("FAIL fullpop_order%0d got %h/%b want %h/1", i, data_out, valid_out, (i == 4) ? 32'h55555555 : w[i]); end
    end
  endtask

  task automatic test_drain();
    logic [31:0] w [3];
    w[0] = 32'hD0000001; w[1] = 32'hD0000002; w[2] = 32'hD0000003;
    do_reset();
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, (i < 3), (i < 3) ? w[i] : 32'h0);
    step(1'b0, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd4 || data_out !== w[0] || valid_out !== 1'b1 || active !== 1'b1)
      begin errors++; $display("FAIL drain_w0 got st=%0d d=%h vo=%b act=%b want 4/%h/1/1", state, data_out, valid_out, active, w[0]); end
    step(1'b0, 2'b11, 1'b1, 32'hDEADBEEF);
    checks++; if (state !== 3'd4 || data_out !== w[1] || overflow !== 1'b1)
      begin errors++; $display("FAIL drain_w1 got st=%0d d=%h ovf=%b want 4/%h/1", state, data_out, overflow, w[1]); end
    step(1'b0, 2'b11, 1'b0, '0);
    checks++; if (state !== 3'd1 || data_out !== w[2] || valid_out !== 1'b1 || active !== 1'b0)
      begin errors++; $display("FAIL drain_last got st=%0d d=%h vo=%b act=%b want 1/%h/1/0", state, data_out, valid_out, active, w[2]); end
    step(1'b0, 2'b11, 1'b0, '0);
    checks++; if (valid_out !== 1'b0 || data_out !== IDLE)
      begin errors++; $display("FAIL drain_done got %h/%b want %h/0", data_out, valid_out, IDLE); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 2'b11, 1'b0, '0);
    step(1'b1, 2'b11, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, (i < 2), 32'hCAFE0000 + 32'(i));
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (state !== 3'd0 || data_out !== IDLE ||
                  {valid_out, active, fifo_full, overflow, error} !== 5'b0)
      begin errors++; $display("FAIL async_reset got st=%0d d=%h flags=%b want 0/%h/00000", state, data_out,
                               {valid_out, active, fifo_full, overflow, error}, IDLE); end
    @(posedge clk_f); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b11, 1'b0, '0);
      checks++; if (valid_out !== 1'b0)
        begin errors++; $display("FAIL async_discard%0d got vo=%b want 0", i, valid_out); end
    end
  endtask

  task automatic test_random();
    logic [39:0] exp_v, act_v;
    logic [1:0]  lo;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      lo = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      step(($urandom_range(0, 15) != 0), lo, 1'($urandom_range(0, 1)), $urandom);
      exp_v = {3'(m_state), m_dout, m_vout, (m_state == M_ACTIVE || m_state == M_DRAIN),
               (m_q.size() == FD), m_ovf, (m_state == M_ERROR)};
      act_v = {state, data_out, valid_out, active, fifo_full, overflow, error};
      checks++;
      if (act_v !== exp_v)
        begin errors++; $display("FAIL random_cyc%0d got %h want %h", cyc, act_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_preload();
    test_lane_glitch();
    test_overflow();
    test_drain();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_tx_ctrl.md
PHY_TX_CTRL -- requirements
Module: phy_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of data words.
REQ-002 Parameter COM_CYCLES, default 4: consecutive lane-good cycles required in IDLE before ACTIVE; legal range 1-15.
REQ-003 Parameter FIFO_DEPTH, default 4: entry count of the holding FIFO; power of two, legal range 2-16.
REQ-004 Parameter IDLE_WORD, default 32'hBCBCBCBC: COM-symbol filler driven on data_out when no payload is sent.
REQ-005 Port clk_f  input  1  sole clock; all flops rise-edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port enable  input  1  link request from the upper layer.
REQ-008 Port lane_ok  input  2  per-lane ready from lane 0 (bit 0) and lane 1 (bit 1).
REQ-009 Port data_input  input  DATA_W  payload word.
REQ-010 Port valid  input  1  data_input qualifier.
REQ-011 Port data_out  output  DATA_W  word toward the striping/serializer path.
REQ-012 Port valid_out  output  1  data_out carries payload.
REQ-013 Port active  output  1  link active; high only in ACTIVE and DRAIN.
REQ-014 Port fifo_full  output  1  FIFO occupancy equals FIFO_DEPTH.
REQ-015 Port overflow  output  1  sticky; set when a word is dropped.
REQ-016 Port error  output  1  high only in ERROR.
REQ-017 Port state  output  3  current FSM state encoding.

Function
REQ-018 FSM encodings SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, DRAIN=4, ERROR=5; all outputs SHALL be registered.
REQ-019 RESET SHALL move to INIT on the first clk_f edge after reset deasserts.
REQ-020 INIT SHALL move to IDLE when enable=1 and lane_ok=2'b11 on the same edge.
REQ-021 IDLE: a 4-bit counter SHALL increment each cycle lane_ok=2'b11, clear to 0 otherwise; at count==COM_CYCLES-1 with lane_ok=2'b11 the FSM SHALL enter ACTIVE and clear the counter.
REQ-022 IDLE with enable=0 SHALL return to INIT (counter cleared), taking priority over REQ-021.
REQ-023 ACTIVE: lane_ok!=2'b11 SHALL enter ERROR (priority over enable); else enable=0 SHALL enter DRAIN.
REQ-024 DRAIN SHALL keep popping; it SHALL enter INIT on the edge the last entry pops (occupancy 1 with pop), or immediately if empty; lane_ok!=2'b11 in DRAIN SHALL enter ERROR.
REQ-025 ERROR SHALL flush the FIFO on entry and move to INIT only when enable=0.
REQ-026 FIFO push SHALL occur when valid=1 in INIT, IDLE or ACTIVE and the FIFO is not full, or is full with a simultaneous pop.
REQ-027 valid=1 in RESET, DRAIN or ERROR, or when full without pop, SHALL drop the word and set overflow, which clears only on reset.
REQ-028 Pop SHALL occur in ACTIVE and DRAIN when occupancy>0; popped word SHALL appear on data_out with valid_out=1 the following cycle.
REQ-029 No bypass: a word pushed on edge k into an empty FIFO SHALL be popped at edge k+1, giving minimum 2-edge input-to-output latency.
REQ-030 Cycles without a pop SHALL drive data_out=IDLE_WORD, valid_out=0.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be a log2(FIFO_DEPTH)+1-bit count, never exceeding FIFO_DEPTH or below 0.
REQ-032 FIFO order SHALL be strict first-in first-out; no word SHALL be duplicated.

Reset
REQ-033 reset=0 SHALL asynchronously force state=RESET, counter=0, pointers and occupancy=0, data_out=IDLE_WORD, valid_out=0, active=0, fifo_full=0, overflow=0, error=0.
REQ-034 reset asserted mid-ACTIVE SHALL discard FIFO contents with no further valid_out pulse.

Verification
REQ-035 Bring-up: reset release, enable=1, lane_ok=11 -> state 1,2 then ACTIVE after 4 IDLE cycles; active=1; data_out=BCBCBCBC, valid_out=0 throughout.
REQ-036 Pre-load: push 0x11111111..0x44444444 in IDLE -> fifo_full=1; in ACTIVE the four words emerge in order on consecutive cycles.
REQ-037 Lane glitch: lane_ok=01 for one cycle at IDLE count 2 -> counter clears; ACTIVE reached 4 good cycles later; same glitch in ACTIVE -> ERROR, error=1, FIFO empty.
REQ-038 Overflow: 5 words while in IDLE -> fifth dropped, overflow=1 persists until reset; full-with-pop push in ACTIVE -> accepted, overflow unchanged.
REQ-039 Drain: 3 words queued, enable=0 in ACTIVE -> DRAIN, 3 words out, INIT on last pop; valid=1 during DRAIN -> overflow=1.
REQ-040 Async reset mid-ACTIVE with 2 words queued -> all outputs at REQ-033 values without a clock edge.
